// File: rtl/gj_pkg.sv
// gj_pkg: shared sizes and FSM state encoding for the Gauss-Jordan solver
package gj_pkg;
  localparam int N = 5;
  localparam int W = 32;
  localparam int ROW_W = $clog2(N);
  localparam int COL_W = $clog2(2 * N);
  localparam int CNT_W = $clog2(2 * N * N + 1);
  typedef enum logic [2:0] {IDLE, LOAD, PIV_CHK, NORM, ELIM, NEXT, DRAIN, ERR} state_t;
endpackage

// File: rtl/gj_div_seq.sv
// gj_div_seq: W-cycle signed restoring divider (clk, rst, start, dividend, divisor -> quotient, done)
module gj_div_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  r_rem, r_q, r_d;
  logic          r_neg, r_busy, r_done;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  w_a_mag, w_b_mag, w_rem, w_q, w_d;
  logic [W:0]    w_sh, w_tr;
  logic          w_ge;
  assign w_a_mag = dividend[W-1] ? -dividend : dividend;
  assign w_b_mag = divisor[W-1] ? -divisor : divisor;
  assign w_rem = start ? '0 : r_rem;
  assign w_q = start ? w_a_mag : r_q;
  assign w_d = start ? w_b_mag : r_d;
  assign w_sh = {w_rem, w_q[W-1]};
  assign w_tr = w_sh - {1'b0, w_d};
  assign w_ge = !w_tr[W];
  assign quotient = r_neg ? -r_q : r_q;
  assign done = r_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_q <= '0;
      r_d <= '0;
      r_neg <= 1'b0;
    end else begin
      r_done <= r_busy && !start && r_cnt == CW'(1);
      if (start || r_busy) begin
        r_rem <= w_ge ? w_tr[W-1:0] : w_sh[W-1:0];
        r_q <= {w_q[W-2:0], w_ge};
      end
      if (start) begin
        r_d <= w_b_mag;
        r_neg <= dividend[W-1] ^ divisor[W-1];
        r_cnt <= CW'(W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_cnt <= r_cnt - 1'b1;
        r_busy <= r_cnt != CW'(1);
      end
    end
  end
endmodule

// File: rtl/gj_solve_seq.sv
// gj_solve_seq: sequential Gauss-Jordan X=A^-1*B; in_* stream A then B, out_* streams X, busy/singular status
module gj_solve_seq
  import gj_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         singular
);
  localparam int RW1 = ROW_W + 1;
  logic [W-1:0]     r_a [N][2*N];
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_p, r_r;
  logic [COL_W-1:0] r_c;
  logic [W-1:0]     r_piv, r_f;
  logic             r_started, r_lat;
  logic             w_div_start, w_div_done, w_lc_last, w_dc_last;
  logic [W-1:0]     w_dq;
  logic [COL_W-1:0] w_lcol, w_pc, w_dnc;
  logic [ROW_W-1:0] w_dnr;
  logic [ROW_W:0]   w_nr1, w_nr;
  assign in_ready = r_state == IDLE || r_state == LOAD;
  assign busy = r_state != IDLE;
  assign w_pc = COL_W'(r_p);
  assign w_lc_last = r_c == COL_W'(N - 1);
  assign w_lcol = r_c + (r_cnt >= CNT_W'(N * N) ? COL_W'(N) : '0);
  assign w_nr1 = {1'b0, r_r} + 1'b1;
  assign w_nr = (w_nr1 == {1'b0, r_p}) ? w_nr1 + 1'b1 : w_nr1;
  assign w_dc_last = r_c == COL_W'(N - 1);
  assign w_dnr = w_dc_last ? r_r + 1'b1 : r_r;
  assign w_dnc = w_dc_last ? '0 : r_c + 1'b1;
  assign w_div_start = r_state == NORM && !r_started;
  gj_div_seq #(.W(W)) u_div (
    .clk(clk),
    .rst(rst),
    .start(w_div_start),
    .dividend(r_a[r_p][r_c]),
    .divisor(r_piv),
    .quotient(w_dq),
    .done(w_div_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_p <= '0;
      r_r <= '0;
      r_c <= '0;
      r_piv <= '0;
      r_f <= '0;
      r_started <= 1'b0;
      r_lat <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      singular <= 1'b0;
    end else begin
      case (r_state)
        IDLE, LOAD: if (in_valid) begin
          r_a[r_r][w_lcol] <= in_data;
          r_cnt <= r_cnt + 1'b1;
          r_c <= w_lc_last ? '0 : r_c + 1'b1;
          r_r <= w_lc_last ? (r_r == ROW_W'(N - 1) ? '0 : r_r + 1'b1) : r_r;
          r_p <= '0;
          if (r_state == IDLE) singular <= 1'b0;
          r_state <= r_cnt == CNT_W'(2 * N * N - 1) ? PIV_CHK : LOAD;
        end
        PIV_CHK: if (r_a[r_p][w_pc] == '0) begin
          singular <= 1'b1;
          r_state <= ERR;
        end else begin
          r_piv <= r_a[r_p][w_pc];
          r_c <= '0;
          r_started <= 1'b0;
          r_state <= NORM;
        end
        NORM: begin
          if (!r_started) r_started <= 1'b1;
          if (w_div_done) begin
            r_a[r_p][r_c] <= w_dq;
            r_started <= 1'b0;
            r_c <= r_c + 1'b1;
            if (r_c == COL_W'(2 * N - 1)) begin
              r_c <= '0;
              r_lat <= 1'b1;
              r_r <= r_p == '0 ? ROW_W'(1) : '0;
              r_state <= ELIM;
            end
          end
        end
        ELIM: if (r_lat) begin
          r_f <= r_a[r_r][w_pc];
          r_lat <= 1'b0;
        end else begin
          r_a[r_r][r_c] <= r_a[r_r][r_c] - r_f * r_a[r_p][r_c];
          r_c <= r_c + 1'b1;
          if (r_c == COL_W'(2 * N - 1)) begin
            r_c <= '0;
            r_lat <= 1'b1;
            r_r <= w_nr[ROW_W-1:0];
            if (w_nr >= RW1'(N)) r_state <= NEXT;
          end
        end
        NEXT: if (r_p == ROW_W'(N - 1)) begin
          r_r <= '0;
          r_c <= '0;
          out_valid <= 1'b1;
          out_data <= r_a[ROW_W'(0)][COL_W'(N)];
          out_last <= 1'b0;
          r_state <= DRAIN;
        end else begin
          r_p <= r_p + 1'b1;
          r_state <= PIV_CHK;
        end
        DRAIN: if (out_ready) begin
          if (out_last) begin
            out_valid <= 1'b0;
            out_last <= 1'b0;
            r_r <= '0;
            r_c <= '0;
            r_cnt <= '0;
            r_state <= IDLE;
          end else begin
            out_data <= r_a[w_dnr][COL_W'(N) + w_dnc];
            out_last <= w_dnr == ROW_W'(N - 1) && w_dnc == COL_W'(N - 1);
            r_r <= w_dnr;
            r_c <= w_dnc;
          end
        end
        ERR: begin
          r_r <= '0;
          r_c <= '0;
          r_cnt <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gj_solve_seq.sv
// tb_gj_solve_seq: randomized scoreboard bench for gj_solve_seq against a plain Gauss-Jordan model
module tb_gj_solve_seq;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [31:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, singular;
  logic [31:0] out_data;
  typedef struct packed {logic [31:0] d; logic l;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0, ready_mode = 0;
  int ga[5][5], gb[5][5];
  gj_solve_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .singular(singular)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic int sdiv(input int a, input int b);
    return (b == -1) ? -a : a / b;
  endfunction
  initial begin
    bit stall = 0;
    logic [31:0] hd = '0;
    logic hl = 0;
    int idx = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      idx++;
      out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? (idx % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hd);
        chk("stall_last", out_last, hl);
      end
      stall = 0;
      if (out_valid && !out_ready) begin
        stall = 1;
        hd = out_data;
        hl = out_last;
      end else if (out_valid) begin
        if (exp_q.size() == 0) chk("out_unexpected", out_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_last", out_last, e.l);
        end
      end
    end
  end
  task automatic send(input logic [31:0] v);
    int n = 0;
    if ($urandom_range(0, 3) == 0) @(negedge clk);
    in_valid = 1;
    in_data = v;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_timeout", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic check_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_singular", singular, 0);
  endtask
  task automatic do_load(input int rmode, input bit abort);
    int m[5][10];
    int piv, f, n;
    bit sing = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        m[r][c] = ga[r][c];
        m[r][5+c] = gb[r][c];
      end
    for (int p = 0; p < 5; p++)
      if (!sing) begin
        if (m[p][p] == 0) sing = 1;
        else begin
          piv = m[p][p];
          for (int c = 0; c < 10; c++) m[p][c] = sdiv(m[p][c], piv);
          for (int r = 0; r < 5; r++)
            if (r != p) begin
              f = m[r][p];
              for (int c = 0; c < 10; c++) m[r][c] = m[r][c] - f * m[p][c];
            end
        end
      end
    if (!sing && !abort)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) exp_q.push_back('{m[r][5+c], r == 4 && c == 4});
    ready_mode = rmode;
    for (int k = 0; k < 50; k++) begin
      send(k < 25 ? ga[k/5][k%5] : gb[(k-25)/5][(k-25)%5]);
      if (k == 0) begin
        chk("first_singular_clear", singular, 0);
        chk("first_busy", busy, 1);
      end
    end
    chk("compute_in_ready", in_ready, 0);
    if (abort) begin
      repeat (1100) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check_reset();
      rst = 0;
      exp_q.delete();
      return;
    end
    n = 0;
    while (!out_valid && busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!sing) chk("latency", n, 1880);
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("done_busy", busy, 0);
    chk("done_singular", singular, sing);
    chk("done_queue_empty", exp_q.size(), 0);
    chk("done_in_ready", in_ready, 1);
    exp_q.delete();
  endtask
  task automatic set_diag(input int da, input int db);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ga[r][c] = r == c ? da : 0;
        gb[r][c] = r == c ? db : 0;
      end
  endtask
  task automatic set_t1();
    set_diag(1, 0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) gb[r][c] = 10 * r + c;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_reset();
    rst = 0;
    @(negedge clk);
    set_t1();
    do_load(0, 0);
    set_diag(2, 4);
    do_load(0, 0);
    set_diag(1, 1);
    ga[0][1] = 3;
    do_load(0, 0);
    set_diag(1, 1);
    ga[0][0] = 0;
    do_load(0, 0);
    set_t1();
    do_load(1, 0);
    set_t1();
    do_load(0, 1);
    set_diag(2, 4);
    do_load(0, 0);
    set_diag(-1, 1);
    gb[0][0] = 32'h8000_0000;
    do_load(2, 0);
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          ga[r][c] = int'($urandom_range(0, 8)) - 4;
          gb[r][c] = int'($urandom_range(0, 2000)) - 1000;
          if (r == c && t < 2) ga[r][c] = ga[r][c] + 13;
        end
      do_load(2, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
